brick_hit_detector: RTL and testbench
=====================================

# brick_hit_detector

Converts pixel-level overlaps between bullet and brick draw requests into at most one tile-addressed hit per bullet per frame. It sits between the VGA drawing/collision layer and the bricks controller. It drives the bricks controller's `brickCollision1X`, `brickCollision1Y` and `collision` inputs, and tells each bullet that it has hit a brick.

## Interface
- `X_OFFSET`, default 48: screen x of the left edge of tile column 0.
- `Y_OFFSET`, default 16: screen y of the top edge of tile row 0.
- `TILE_SHIFT`, default 5: log2 of the tile size in pixels (32×32 tiles).
- `clk`  in  1  system clock.
- `resetN`  in  1  synchronous, active-low reset.
- `startOfFrame`  in  1  one-cycle pulse at the start of each VGA frame.
- `pixelX`  in  11  current pixel x.
- `pixelY`  in  11  current pixel y.
- `bricksDR`  in  1  a brick is drawn at the current pixel.
- `bullet1DR`  in  1  bullet 1 is drawn at the current pixel.
- `bullet2DR`  in  1  bullet 2 is drawn at the current pixel.
- `brickCollision1X`  out  5  tile column of the issued hit (0..16).
- `brickCollision1Y`  out  4  tile row of the issued hit (0..13).
- `collision`  out  1  one-cycle hit pulse to the bricks controller.
- `bullet1Hit`  out  1  one-cycle pulse: bullet 1's hit is being issued.
- `bullet2Hit`  out  1  one-cycle pulse: bullet 2's hit is being issued.

## Operation
- **Stage S1 (registered):**
  - `dx = pixelX - X_OFFSET`, `dy = pixelY - Y_OFFSET` (unsigned, 11 bit).
  - `col = dx >> TILE_SHIFT`, `row = dy >> TILE_SHIFT`.
  - `inGrid = (pixelX >= X_OFFSET) && (pixelY >= Y_OFFSET) && col < 17 && row < 14`.
  - `hitK = bricksDR && bulletKDR && inGrid`.
  - S1 stores `hit1`, `hit2`, `col[4:0]`, `row[3:0]`.
- **Per-bullet state:**
  - `armedK`: the bullet may still report a hit this frame.
  - `pendK`: valid bit plus col and row.
- **Capture:** when S1 `hitK && armedK && !pendK.valid`:
  - load `pendK` with the S1 col/row;
  - clear `armedK`.
  - If `pendK` is already valid, the capture is dropped and `armedK` stays set.
- **Re-arm:** `startOfFrame` sets `armed1 = armed2 = 1`. It takes priority over a same-edge clear. A same-edge capture still uses the pre-edge `armed` value. Pending entries are never cleared by `startOfFrame`.
- **Issue:** each cycle at most one pending entry is granted.
  - If only one is valid, grant it.
  - If both are valid, grant the one indicated by the round-robin pointer `rr` (0 = bullet 1). `rr` toggles after every two-way contention grant.
  - On a grant the registered outputs are `collision = 1`, `brickCollision1X/Y` = the entry's col/row, and `bulletKHit = 1` for the granted bullet. The granted `pendK.valid` clears on the same edge.
  - Without a grant, `collision`, `bullet1Hit`, `bullet2Hit` = 0 and `brickCollision1X/Y` = 0.
- **Both bullets on the same tile:** two separate hits are issued on consecutive cycles. The brick loses two health levels. This is intended.
- **Reset (`resetN` low at a clk edge):**
  - all outputs 0;
  - S1 cleared;
  - `pend1`, `pend2` invalid;
  - `armed1 = armed2 = 1`;
  - `rr = 0`.
  - A reset mid-operation discards all pending hits.

## Timing
- The overlap pixel is sampled at edge N into S1.
- Capture into `pendK` happens at edge N+1.
- `collision` and `bulletKHit` are high for exactly the one cycle following edge N+2. Latency is 3 edges for an uncontended hit; a contended second hit issues one cycle later.
- A new capture into `pendK` is possible at the same edge at which `pendK` is issued-and-cleared only if the capture sees `!valid` pre-edge. Otherwise it is dropped. Dropping is harmless because `armedK` stays set.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- **Single hit:**
  - Stimulus: after reset, one cycle with `bricksDR = bullet1DR = 1`, `pixelX = 277`, `pixelY = 147`.
  - Response: `collision = 1`, X = 7, Y = 4, `bullet1Hit = 1` for exactly one cycle, 3 edges later.
- **Per-frame dedup:**
  - Stimulus: 40 consecutive overlap pixels for bullet 1 in tile (7,4), then `startOfFrame`, then the same again.
  - Response: exactly one `collision` pulse per frame, 2 in total.
- **Contention:**
  - Stimulus: a bullet 1 and bullet 2 overlap on the same cycle at `pixelX = 48`, `pixelY = 16`.
  - Response: pulses on two consecutive cycles, X = 0, Y = 0. First `bullet1Hit`, then `bullet2Hit`; `rr` becomes 1.
  - Follow-up: repeat next frame; the order becomes bullet 2 then bullet 1.
- **Out of grid:**
  - Stimulus: overlaps at `pixelX = 47`; at `pixelX = 48 + 17*32 = 592`; at `pixelY = 16 + 14*32 = 464`.
  - Response: no `collision` and no `bulletKHit`.
- **Missing draw request:**
  - Stimulus: `bullet1DR = 1` with `bricksDR = 0`.
  - Response: no pulse, and `armed1` remains set. A later real overlap in the same frame produces a hit.
- **Reset mid-operation:**
  - Stimulus: an overlap at edge N, then `resetN = 0` at edge N+1.
  - Response: no `collision` pulse ever appears for it, and all outputs are 0 after reset.
  - Follow-up: a new overlap after reset is reported normally.

Source files
------------

// File: rtl/brick_hit_detector.sv
`default_nettype none
// ============================================================================
// Module   : brick_hit_detector
// Purpose  : Turns pixel-level bullet/brick overlaps into at most one
//            tile-addressed hit per bullet per frame, issued one at a time
//            to the bricks controller.
// Ports    : clk, resetN (sync, active-low), startOfFrame (frame pulse),
//            pixelX/pixelY (current pixel), bricksDR/bullet1DR/bullet2DR
//            (draw requests), brickCollision1X/Y (tile of issued hit),
//            collision (hit pulse), bullet1Hit/bullet2Hit (per-bullet pulse).
// Revision : 1.0 - initial release
// ============================================================================
module brick_hit_detector #(
  parameter int X_OFFSET   = 48,
  parameter int Y_OFFSET   = 16,
  parameter int TILE_SHIFT = 5
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        bricksDR,
  input  logic        bullet1DR,
  input  logic        bullet2DR,
  output logic [4:0]  brickCollision1X,
  output logic [3:0]  brickCollision1Y,
  output logic        collision,
  output logic        bullet1Hit,
  output logic        bullet2Hit
);

  localparam logic [10:0] X_OFF = 11'(X_OFFSET);
  localparam logic [10:0] Y_OFF = 11'(Y_OFFSET);

  // Grid geometry (combinational, feeds stage S1)
  logic [10:0] dx, dy, col_full, row_full;
  logic        in_grid, hit1_c, hit2_c;

  always_comb begin
    dx       = pixelX - X_OFF;
    dy       = pixelY - Y_OFF;
    col_full = dx >> TILE_SHIFT;
    row_full = dy >> TILE_SHIFT;
    // Off-grid pixels left/above would wrap dx/dy, so test them explicitly.
    in_grid  = (pixelX >= X_OFF) && (pixelY >= Y_OFF) &&
               (col_full < 11'd17) && (row_full < 11'd14);
    hit1_c   = bricksDR && bullet1DR && in_grid;
    hit2_c   = bricksDR && bullet2DR && in_grid;
  end

  // Stage S1
  logic       s1_hit1, s1_hit2;
  logic [4:0] s1_col;
  logic [3:0] s1_row;

  // Per-bullet state
  logic       armed1, armed2;
  logic       pend1_valid, pend2_valid;
  logic [4:0] pend1_col, pend2_col;
  logic [3:0] pend1_row, pend2_row;
  logic       rr;

  // Capture and grant decisions use pre-edge state only.
  logic cap1, cap2, grant1, grant2, contend;

  always_comb begin
    cap1    = s1_hit1 && armed1 && !pend1_valid;
    cap2    = s1_hit2 && armed2 && !pend2_valid;
    contend = pend1_valid && pend2_valid;
    grant1  = pend1_valid && (!pend2_valid || !rr);
    grant2  = pend2_valid && (!pend1_valid ||  rr);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      s1_hit1          <= 1'b0;
      s1_hit2          <= 1'b0;
      s1_col           <= '0;
      s1_row           <= '0;
      armed1           <= 1'b1;
      armed2           <= 1'b1;
      pend1_valid      <= 1'b0;
      pend2_valid      <= 1'b0;
      pend1_col        <= '0;
      pend1_row        <= '0;
      pend2_col        <= '0;
      pend2_row        <= '0;
      rr               <= 1'b0;
      collision        <= 1'b0;
      bullet1Hit       <= 1'b0;
      bullet2Hit       <= 1'b0;
      brickCollision1X <= '0;
      brickCollision1Y <= '0;
    end else begin
      s1_hit1 <= hit1_c;
      s1_hit2 <= hit2_c;
      s1_col  <= col_full[4:0];
      s1_row  <= row_full[3:0];

      // A frame start re-arms even when the same edge captures.
      if (startOfFrame)  armed1 <= 1'b1;
      else if (cap1)     armed1 <= 1'b0;
      if (startOfFrame)  armed2 <= 1'b1;
      else if (cap2)     armed2 <= 1'b0;

      // Capture requires !valid and grant requires valid, so they never
      // collide on the same entry within one edge.
      if (cap1) begin
        pend1_valid <= 1'b1;
        pend1_col   <= s1_col;
        pend1_row   <= s1_row;
      end else if (grant1) begin
        pend1_valid <= 1'b0;
      end
      if (cap2) begin
        pend2_valid <= 1'b1;
        pend2_col   <= s1_col;
        pend2_row   <= s1_row;
      end else if (grant2) begin
        pend2_valid <= 1'b0;
      end

      if (contend) rr <= ~rr;

      collision  <= grant1 || grant2;
      bullet1Hit <= grant1;
      bullet2Hit <= grant2;
      if (grant1) begin
        brickCollision1X <= pend1_col;
        brickCollision1Y <= pend1_row;
      end else if (grant2) begin
        brickCollision1X <= pend2_col;
        brickCollision1Y <= pend2_row;
      end else begin
        brickCollision1X <= '0;
        brickCollision1Y <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_brick_hit_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_brick_hit_detector
// Purpose  : Self-checking bench for brick_hit_detector: a per-cycle vector
//            table plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_brick_hit_detector;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY;
  logic        bricksDR, bullet1DR, bullet2DR;
  logic [4:0]  brickCollision1X;
  logic [3:0]  brickCollision1Y;
  logic        collision, bullet1Hit, bullet2Hit;

  brick_hit_detector dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .pixelX           (pixelX),
    .pixelY           (pixelY),
    .bricksDR         (bricksDR),
    .bullet1DR        (bullet1DR),
    .bullet2DR        (bullet2DR),
    .brickCollision1X (brickCollision1X),
    .brickCollision1Y (brickCollision1Y),
    .collision        (collision),
    .bullet1Hit       (bullet1Hit),
    .bullet2Hit       (bullet2Hit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sof, br, b1, b2;
    logic [10:0] x, y;
    logic        coll;
    logic [4:0]  ex;
    logic [3:0]  ey;
    logic        h1, h2;
  } vec_t;

  function automatic vec_t mk(logic sof, logic br, logic b1, logic b2,
                              int x, int y, logic coll, int ex, int ey,
                              logic h1, logic h2);
    vec_t v;
    v.sof = sof; v.br = br; v.b1 = b1; v.b2 = b2;
    v.x = 11'(x); v.y = 11'(y);
    v.coll = coll; v.ex = 5'(ex); v.ey = 4'(ey); v.h1 = h1; v.h2 = h2;
    return v;
  endfunction

  // Output bundle {collision, X, Y, bullet1Hit, bullet2Hit}
  function automatic logic [11:0] outs();
    return {collision, brickCollision1X, brickCollision1Y, bullet1Hit, bullet2Hit};
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got coll/X/Y/h1/h2 = %b/%0d/%0d/%b/%b, want %b/%0d/%0d/%b/%b",
               name, act[11], act[10:6], act[5:2], act[1], act[0],
               exp[11], exp[10:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(logic sof, logic br, logic b1, logic b2, int x, int y);
    startOfFrame = sof; bricksDR = br; bullet1DR = b1; bullet2DR = b2;
    pixelX = 11'(x); pixelY = 11'(y);
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  localparam int NV = 32;
  vec_t vt [NV];

  int cnt, cnt_f1, lat;
  logic seen;

  initial begin
    // Expected outputs in row i are those seen right after row i's edge;
    // an overlap in row i appears in row i+2 (three edges counting S1).
    vt[0]  = mk(0,1,1,0, 277,147, 0, 0, 0,0,0);  // single hit (7,4)
    vt[1]  = mk(0,0,0,0,   0,  0, 0, 0, 0,0,0);
    vt[2]  = mk(0,0,0,0,   0,  0, 1, 7, 4,1,0);
    vt[3]  = mk(0,0,0,0,   0,  0, 0, 0, 0,0,0);
    vt[4]  = mk(1,0,0,0,   0,  0, 0, 0, 0,0,0);  // new frame
    vt[5]  = mk(0,1,1,1,  48, 16, 0, 0, 0,0,0);  // contention at (0,0)
    vt[6]  = mk(0,0,0,0,   0,  0, 0, 0, 0,0,0);
    vt[7]  = mk(0,0,0,0,   0,  0, 1, 0, 0,1,0);
    vt[8]  = mk(0,0,0,0,   0,  0, 1, 0, 0,0,1);
    vt[9]  = mk(1,0,0,0,   0,  0, 0, 0, 0,0,0);
    vt[10] = mk(0,1,1,1,  48, 16, 0, 0, 0,0,0);  // rr now favours bullet 2
    vt[11] = mk(0,0,0,0,   0,  0, 0, 0, 0,0,0);
    vt[12] = mk(0,0,0,0,   0,  0, 1, 0, 0,0,1);
    vt[13] = mk(0,0,0,0,   0,  0, 1, 0, 0,1,0);
    vt[14] = mk(1,0,0,0,   0,  0, 0, 0, 0,0,0);
    vt[15] = mk(0,1,1,1,  47,147, 0, 0, 0,0,0);  // left of grid
    vt[16] = mk(0,1,1,1, 592,147, 0, 0, 0,0,0);  // right of grid
    vt[17] = mk(0,1,1,1, 300,464, 0, 0, 0,0,0);  // below grid
    vt[18] = mk(0,1,1,1, 300, 15, 0, 0, 0,0,0);  // above grid
    vt[19] = mk(0,0,1,0, 277,147, 0, 0, 0,0,0);  // no brick drawn
    vt[20] = mk(0,0,0,0,   0,  0, 0, 0, 0,0,0);
    vt[21] = mk(0,0,0,0,   0,  0, 0, 0, 0,0,0);
    vt[22] = mk(0,1,1,0, 591,463, 0, 0, 0,0,0);  // last tile (16,13), still armed
    vt[23] = mk(0,0,0,0,   0,  0, 0, 0, 0,0,0);
    vt[24] = mk(0,0,0,0,   0,  0, 1,16,13,1,0);
    vt[25] = mk(1,0,0,0,   0,  0, 0, 0, 0,0,0);
    vt[26] = mk(0,1,1,0, 277,147, 0, 0, 0,0,0);
    vt[27] = mk(1,0,0,0,   0,  0, 0, 0, 0,0,0);  // frame start on the capture edge
    vt[28] = mk(0,1,1,0, 277,147, 1, 7, 4,1,0);  // re-armed: overlap hits again
    vt[29] = mk(0,0,0,0,   0,  0, 0, 0, 0,0,0);
    vt[30] = mk(0,0,0,0,   0,  0, 1, 7, 4,1,0);
    vt[31] = mk(0,0,0,0,   0,  0, 0, 0, 0,0,0);

    // Reset
    resetN = 1'b0;
    idle();
    tick(); tick();
    check("reset_state", outs(), 12'd0);
    resetN = 1'b1;

    // Table
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].sof, vt[i].br, vt[i].b1, vt[i].b2, vt[i].x, vt[i].y);
      tick();
      check($sformatf("vec%0d", i), outs(),
            {vt[i].coll, vt[i].ex, vt[i].ey, vt[i].h1, vt[i].h2});
    end
    idle(); tick(); tick();

    // Per-frame dedup: 40 overlaps per frame, one pulse per frame
    cnt = 0;
    for (int f = 0; f < 2; f++) begin
      drive(1, 0, 0, 0, 0, 0); tick();
      if (collision) cnt++;
      for (int i = 0; i < 40; i++) begin
        drive(0, 1, 1, 0, 272 + (i % 32), 144 + (i % 8));
        tick();
        if (collision) begin
          cnt++;
          check("dedup_tile", outs(), {1'b1, 5'd7, 4'd4, 1'b1, 1'b0});
        end
      end
      idle();
      for (int i = 0; i < 4; i++) begin tick(); if (collision) cnt++; end
      if (f == 0) begin
        cnt_f1 = cnt;
        check("dedup_frame1", {11'd0, cnt_f1 == 1}, 12'd1);
      end
    end
    check("dedup_total", 12'(cnt), 12'd2);

    // Reset mid-operation: overlap at edge N, reset at edge N+1
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 1, 277, 147); tick();
    idle(); resetN = 1'b0; tick();
    check("rst_mid_outs", outs(), 12'd0);
    tick();
    resetN = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (collision || bullet1Hit || bullet2Hit) cnt++; end
    check("rst_mid_nopulse", 12'(cnt), 12'd0);

    // New overlap after reset: expect a hit exactly three edges later
    drive(0, 1, 0, 1, 400, 200); tick();   // (11,5)
    idle();
    seen = 1'b0; lat = 1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(); lat++;
      if (collision) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL post_rst_timeout: got no collision within 10 cycles, want a pulse");
    end else begin
      check("post_rst_hit", outs(), {1'b1, 5'd11, 4'd5, 1'b0, 1'b1});
      check("post_rst_latency", 12'(lat), 12'd3);
      tick();
      check("post_rst_oneshot", outs(), 12'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
